// File: rtl/hsv_color_tracker_pkg.sv
// Shared constants for the HSV colour tracker: pixel component ranges and
// centroid-divider FSM state encodings.
package hsv_color_tracker_pkg;

    localparam int HUE_MAX = 359;
    localparam int S_FULL  = 256;
    localparam int HUE_W   = $clog2(HUE_MAX + 1);
    localparam int SAT_W   = $clog2(S_FULL + 1);

    localparam logic [1:0] DIV_IDLE = 2'd0;
    localparam logic [1:0] DIV_X    = 2'd1;
    localparam logic [1:0] DIV_Y    = 2'd2;
    localparam logic [1:0] DIV_DONE = 2'd3;

    // Hue window test; lo > hi means the window wraps through 0 (red).
    function automatic logic hue_in_window(input logic [HUE_W-1:0] h,
                                           input logic [HUE_W-1:0] lo,
                                           input logic [HUE_W-1:0] hi);
        if (lo <= hi) return (h >= lo) && (h <= hi);
        else          return (h >= lo) || (h <= hi);
    endfunction

endpackage

// File: rtl/hsv_color_tracker_seq_divider.sv
// Restoring unsigned divider, one quotient bit per clock (W clocks per divide).
// Handshake: start is a 1-clk strobe that captures dividend/divisor; busy is
// high while iterating; done is a 1-clk strobe with quotient valid on the same
// clk. start has priority over abort; abort drops busy and suppresses done.
module hsv_color_tracker_seq_divider #(
    parameter int W  = 33,
    parameter int DW = 22,
    parameter int QW = 11
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic          abort,
    input  logic [W-1:0]  dividend,
    input  logic [DW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [QW-1:0] quotient
);

    localparam int CW = $clog2(W);

    logic [W-1:0]  quo_q, quo_d;
    logic [DW-1:0] rem_q, rem_d;
    logic [DW-1:0] div_q, div_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [DW:0]   trial;
    logic [DW:0]   diff;

    // One restoring step per clock; diff[DW] is the borrow (trial < divisor).
    always_comb begin
        trial  = {rem_q, quo_q[W-1]};
        diff   = trial - {1'b0, div_q};
        quo_d  = quo_q;
        rem_d  = rem_q;
        div_d  = div_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        if (start) begin
            quo_d  = dividend;
            rem_d  = '0;
            div_d  = divisor;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (abort) begin
            busy_d = 1'b0;
        end else if (busy_q) begin
            quo_d = {quo_q[W-2:0], ~diff[DW]};
            rem_d = diff[DW] ? trial[DW-1:0] : diff[DW-1:0];
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(W - 1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    // Divider state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            quo_q  <= '0;
            rem_q  <= '0;
            div_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            div_q  <= div_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign quotient = quo_q[QW-1:0];

endmodule

// File: rtl/hsv_color_tracker.sv
// HSV window classifier with registered mask stream, per-frame bounding box,
// pixel count and coordinate sums, and a sequential centroid computation.
module hsv_color_tracker
    import hsv_color_tracker_pkg::*;
#(
    parameter int   X_W     = 11,
    parameter int   Y_W     = 11,
    parameter int   CNT_W   = 22,
    parameter int   SUM_W   = 33,
    parameter int   MIN_PIX = 64,
    parameter logic VS_POL  = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [HUE_W-1:0] hsv_h,
    input  logic [SAT_W-1:0] hsv_s,
    input  logic [7:0]       hsv_v,
    input  logic             hsv_vs,
    input  logic             hsv_hs,
    input  logic             hsv_de,
    input  logic             hsv_valid,
    input  logic [HUE_W-1:0] h_min,
    input  logic [HUE_W-1:0] h_max,
    input  logic [SAT_W-1:0] s_min,
    input  logic [7:0]       v_min,
    output logic             mask,
    output logic             mask_vs,
    output logic             mask_hs,
    output logic             mask_de,
    output logic             mask_valid,
    output logic             obj_found,
    output logic [X_W-1:0]   bbox_x0,
    output logic [X_W-1:0]   bbox_x1,
    output logic [Y_W-1:0]   bbox_y0,
    output logic [Y_W-1:0]   bbox_y1,
    output logic [CNT_W-1:0] pix_count,
    output logic [X_W-1:0]   cen_x,
    output logic [Y_W-1:0]   cen_y,
    output logic             frame_done,
    output logic             result_valid,
    output logic [1:0]       dbg_div_state
);

    localparam int QW = (X_W > Y_W) ? X_W : Y_W;

    logic             vs_act_q;
    logic [HUE_W-1:0] h_min_q, h_max_q, h_min_e, h_max_e;
    logic [SAT_W-1:0] s_min_q, s_min_e;
    logic [7:0]       v_min_q, v_min_e;
    logic             mask_q, mask_vs_q, mask_hs_q, mask_de_q, mask_valid_q;
    logic [X_W-1:0]   x_q, x_d;
    logic [Y_W-1:0]   y_q, y_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_base;
    logic [SUM_W-1:0] sum_x_q, sum_x_d, sum_x_base;
    logic [SUM_W-1:0] sum_y_q, sum_y_d, sum_y_base;
    logic [SUM_W:0]   sx_ext, sy_ext;
    logic [X_W-1:0]   bx0_q, bx0_d, bx0_base, bx1_q, bx1_d, bx1_base;
    logic [Y_W-1:0]   by0_q, by0_d, by0_base, by1_q, by1_d, by1_base;
    logic [CNT_W-1:0] pix_count_q;
    logic             obj_found_q, frame_done_q, result_valid_q, result_valid_d;
    logic [X_W-1:0]   bbox_x0_q, bbox_x1_q, qx_q, qx_d, cen_x_q, cen_x_d;
    logic [Y_W-1:0]   bbox_y0_q, bbox_y1_q, qy_q, qy_d, cen_y_q, cen_y_d;
    logic [SUM_W-1:0] sum_y_lat_q;
    logic [1:0]       state_q, state_d;
    logic             frame_start, de_fall, hit;
    logic             div_start, div_abort, div_busy, div_done;
    logic [SUM_W-1:0] div_dividend;
    logic [CNT_W-1:0] div_divisor;
    logic [QW-1:0]    div_quot;

    // Frame edge detect and classification; a frame-start clk already uses the new thresholds.
    always_comb begin
        frame_start = (hsv_vs == VS_POL) && !vs_act_q;
        de_fall     = mask_de_q && !hsv_de;
        h_min_e     = frame_start ? h_min : h_min_q;
        h_max_e     = frame_start ? h_max : h_max_q;
        s_min_e     = frame_start ? s_min : s_min_q;
        v_min_e     = frame_start ? v_min : v_min_q;
        hit         = hue_in_window(hsv_h, h_min_e, h_max_e) && (hsv_s >= s_min_e) &&
                      (hsv_v >= v_min_e) && hsv_de && hsv_valid;
    end

    // Pixel column/row counters.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (!hsv_de)                         x_d = '0;
        else if (hsv_valid && (x_q != '1))   x_d = x_q + X_W'(1);
        if (frame_start)                     y_d = '0;
        else if (de_fall && (y_q != '1))     y_d = y_q + Y_W'(1);
    end

    // Saturating accumulators; a hit on the frame-start clk seeds the new frame.
    always_comb begin
        cnt_base   = frame_start ? '0 : cnt_q;
        sum_x_base = frame_start ? '0 : sum_x_q;
        sum_y_base = frame_start ? '0 : sum_y_q;
        bx0_base   = frame_start ? '1 : bx0_q;
        bx1_base   = frame_start ? '0 : bx1_q;
        by0_base   = frame_start ? '1 : by0_q;
        by1_base   = frame_start ? '0 : by1_q;
        sx_ext     = {1'b0, sum_x_base} + {{(SUM_W + 1 - X_W){1'b0}}, x_q};
        sy_ext     = {1'b0, sum_y_base} + {{(SUM_W + 1 - Y_W){1'b0}}, y_q};
        cnt_d      = cnt_base;
        sum_x_d    = sum_x_base;
        sum_y_d    = sum_y_base;
        bx0_d      = bx0_base;
        bx1_d      = bx1_base;
        by0_d      = by0_base;
        by1_d      = by1_base;
        if (hit) begin
            cnt_d   = (cnt_base == '1) ? cnt_base : cnt_base + CNT_W'(1);
            sum_x_d = sx_ext[SUM_W] ? '1 : sx_ext[SUM_W-1:0];
            sum_y_d = sy_ext[SUM_W] ? '1 : sy_ext[SUM_W-1:0];
            bx0_d   = (x_q < bx0_base) ? x_q : bx0_base;
            bx1_d   = (x_q > bx1_base) ? x_q : bx1_base;
            by0_d   = (y_q < by0_base) ? y_q : by0_base;
            by1_d   = (y_q > by1_base) ? y_q : by1_base;
        end
    end

    // Centroid FSM: a new frame always restarts the divide, so stale results never publish.
    always_comb begin
        state_d        = state_q;
        div_start      = 1'b0;
        div_abort      = 1'b0;
        div_dividend   = sum_x_q;
        div_divisor    = cnt_q;
        qx_d           = qx_q;
        qy_d           = qy_q;
        cen_x_d        = cen_x_q;
        cen_y_d        = cen_y_q;
        result_valid_d = 1'b0;
        if (frame_start) begin
            if (cnt_q != '0) begin
                div_start = 1'b1;
                state_d   = DIV_X;
            end else begin
                div_abort = 1'b1;
                qx_d      = '0;
                qy_d      = '0;
                state_d   = DIV_DONE;
            end
        end else begin
            case (state_q)
                DIV_X: begin
                    if (div_done) begin
                        qx_d         = div_quot[X_W-1:0];
                        div_start    = 1'b1;
                        div_dividend = sum_y_lat_q;
                        div_divisor  = pix_count_q;
                        state_d      = DIV_Y;
                    end else if (!div_busy) begin
                        state_d = DIV_IDLE;
                    end
                end
                DIV_Y: begin
                    if (div_done) begin
                        qy_d    = div_quot[Y_W-1:0];
                        state_d = DIV_DONE;
                    end else if (!div_busy) begin
                        state_d = DIV_IDLE;
                    end
                end
                DIV_DONE: begin
                    cen_x_d        = qx_q;
                    cen_y_d        = qy_q;
                    result_valid_d = 1'b1;
                    state_d        = DIV_IDLE;
                end
                default: state_d = DIV_IDLE;
            endcase
        end
    end

    hsv_color_tracker_seq_divider #(
        .W  (SUM_W),
        .DW (CNT_W),
        .QW (QW)
    ) u_div (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (div_start),
        .abort    (div_abort),
        .dividend (div_dividend),
        .divisor  (div_divisor),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quot)
    );

    // All state registers; frame-boundary latch happens on the frame-start clk.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vs_act_q       <= 1'b0;
            h_min_q        <= '0;
            h_max_q        <= '0;
            s_min_q        <= '0;
            v_min_q        <= '0;
            mask_q         <= 1'b0;
            mask_vs_q      <= 1'b0;
            mask_hs_q      <= 1'b0;
            mask_de_q      <= 1'b0;
            mask_valid_q   <= 1'b0;
            x_q            <= '0;
            y_q            <= '0;
            cnt_q          <= '0;
            sum_x_q        <= '0;
            sum_y_q        <= '0;
            bx0_q          <= '0;
            bx1_q          <= '0;
            by0_q          <= '0;
            by1_q          <= '0;
            pix_count_q    <= '0;
            obj_found_q    <= 1'b0;
            bbox_x0_q      <= '0;
            bbox_x1_q      <= '0;
            bbox_y0_q      <= '0;
            bbox_y1_q      <= '0;
            sum_y_lat_q    <= '0;
            frame_done_q   <= 1'b0;
            state_q        <= DIV_IDLE;
            qx_q           <= '0;
            qy_q           <= '0;
            cen_x_q        <= '0;
            cen_y_q        <= '0;
            result_valid_q <= 1'b0;
        end else begin
            vs_act_q       <= (hsv_vs == VS_POL);
            h_min_q        <= h_min_e;
            h_max_q        <= h_max_e;
            s_min_q        <= s_min_e;
            v_min_q        <= v_min_e;
            mask_q         <= hit;
            mask_vs_q      <= hsv_vs;
            mask_hs_q      <= hsv_hs;
            mask_de_q      <= hsv_de;
            mask_valid_q   <= hsv_valid;
            x_q            <= x_d;
            y_q            <= y_d;
            cnt_q          <= cnt_d;
            sum_x_q        <= sum_x_d;
            sum_y_q        <= sum_y_d;
            bx0_q          <= bx0_d;
            bx1_q          <= bx1_d;
            by0_q          <= by0_d;
            by1_q          <= by1_d;
            frame_done_q   <= frame_start;
            if (frame_start) begin
                pix_count_q <= cnt_q;
                obj_found_q <= (cnt_q >= CNT_W'(MIN_PIX));
                bbox_x0_q   <= (cnt_q == '0) ? '0 : bx0_q;
                bbox_x1_q   <= (cnt_q == '0) ? '0 : bx1_q;
                bbox_y0_q   <= (cnt_q == '0) ? '0 : by0_q;
                bbox_y1_q   <= (cnt_q == '0) ? '0 : by1_q;
                sum_y_lat_q <= sum_y_q;
            end
            state_q        <= state_d;
            qx_q           <= qx_d;
            qy_q           <= qy_d;
            cen_x_q        <= cen_x_d;
            cen_y_q        <= cen_y_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign mask          = mask_q;
    assign mask_vs       = mask_vs_q;
    assign mask_hs       = mask_hs_q;
    assign mask_de       = mask_de_q;
    assign mask_valid    = mask_valid_q;
    assign obj_found     = obj_found_q;
    assign bbox_x0       = bbox_x0_q;
    assign bbox_x1       = bbox_x1_q;
    assign bbox_y0       = bbox_y0_q;
    assign bbox_y1       = bbox_y1_q;
    assign pix_count     = pix_count_q;
    assign cen_x         = cen_x_q;
    assign cen_y         = cen_y_q;
    assign frame_done    = frame_done_q;
    assign result_valid  = result_valid_q;
    assign dbg_div_state = state_q;

endmodule

// File: tb/tb_hsv_color_tracker.sv
// Directed bench for hsv_color_tracker: classifier windows, frame statistics,
// centroid publication, abort on short vblank, and asynchronous reset.
module tb_hsv_color_tracker;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [8:0]  hsv_h, hsv_s, h_min, h_max, s_min;
    logic [7:0]  hsv_v, v_min;
    logic        hsv_vs, hsv_hs, hsv_de, hsv_valid;
    logic        mask, mask_vs, mask_hs, mask_de, mask_valid;
    logic        obj_found, frame_done, result_valid;
    logic [10:0] bbox_x0, bbox_x1, bbox_y0, bbox_y1, cen_x, cen_y;
    logic [21:0] pix_count;
    logic [1:0]  dbg_div_state;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int fd_cnt = 0, rv_cnt = 0, fd_cyc = 0, rv_cyc = 0;
    int rv_before, fd_before;

    hsv_color_tracker dut (
        .clk(clk), .reset_n(reset_n),
        .hsv_h(hsv_h), .hsv_s(hsv_s), .hsv_v(hsv_v),
        .hsv_vs(hsv_vs), .hsv_hs(hsv_hs), .hsv_de(hsv_de), .hsv_valid(hsv_valid),
        .h_min(h_min), .h_max(h_max), .s_min(s_min), .v_min(v_min),
        .mask(mask), .mask_vs(mask_vs), .mask_hs(mask_hs), .mask_de(mask_de),
        .mask_valid(mask_valid), .obj_found(obj_found),
        .bbox_x0(bbox_x0), .bbox_x1(bbox_x1), .bbox_y0(bbox_y0), .bbox_y1(bbox_y1),
        .pix_count(pix_count), .cen_x(cen_x), .cen_y(cen_y),
        .frame_done(frame_done), .result_valid(result_valid),
        .dbg_div_state(dbg_div_state)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor, sampled on the inactive edge.
    always @(negedge clk) begin
        if (frame_done) begin
            fd_cnt <= fd_cnt + 1;
            fd_cyc <= cyc;
        end
        if (result_valid) begin
            rv_cnt <= rv_cnt + 1;
            rv_cyc <= cyc;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive(input int h, input int s, input int v, input int vs, input int de);
        @(posedge clk);
        #1;
        hsv_h     = 9'(h);
        hsv_s     = 9'(s);
        hsv_v     = 8'(v);
        hsv_vs    = (vs != 0);
        hsv_de    = (de != 0);
        hsv_hs    = (de == 0);
        hsv_valid = (de != 0);
    endtask

    task automatic send_vs();
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0);
    endtask

    task automatic send_frame(input int w, input int nh, input int rx0, input int rx1,
                              input int ry0, input int ry1);
        for (int y = 0; y < nh; y++) begin
            for (int x = 0; x < w; x++) begin
                if (x >= rx0 && x <= rx1 && y >= ry0 && y <= ry1) drive(120, 200, 100, 0, 1);
                else                                               drive(200, 200, 100, 0, 1);
            end
            drive(0, 0, 0, 0, 0);
            drive(0, 0, 0, 0, 0);
        end
    endtask

    task automatic mask_chk(input string tag, input int h, input int s, input int v, input int exp);
        drive(h, s, v, 0, 1);
        drive(0, 0, 0, 0, 0);
        check(tag, int'(mask), exp);
    endtask

    task automatic wait_rv(input string tag, input int budget);
        int start;
        start = rv_cnt;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (rv_cnt != start) break;
        end
        check(tag, int'(rv_cnt != start), 1);
    endtask

    initial begin
        reset_n = 1'b0;
        hsv_h = '0; hsv_s = '0; hsv_v = '0;
        hsv_vs = 1'b0; hsv_hs = 1'b1; hsv_de = 1'b0; hsv_valid = 1'b0;
        h_min = 9'd100; h_max = 9'd140; s_min = 9'd64; v_min = 8'd32;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pix_count", int'(pix_count), 0);
        check("rst_frame_done", int'(frame_done), 0);
        check("rst_result_valid", int'(result_valid), 0);
        check("rst_cen_x", int'(cen_x), 0);
        check("rst_obj_found", int'(obj_found), 0);
        check("rst_mask", int'(mask), 0);
        check("rst_state", int'(dbg_div_state), 0);
        @(negedge clk);
        reset_n = 1'b1;

        // First frame boundary after reset: empty statistics.
        send_vs();
        check("first_fd_cnt", fd_cnt, 1);
        check("first_pix_count", int'(pix_count), 0);
        check("first_obj_found", int'(obj_found), 0);
        wait_rv("first_rv", 10);
        check("first_rv_lat", rv_cyc - fd_cyc, 1);

        // Test 1: window h 100..140, s>=64, v>=32.
        drive(120, 200, 100, 0, 1);
        check("t1_latency_mask", int'(mask), 0);
        drive(0, 0, 0, 0, 0);
        check("t1_in_window", int'(mask), 1);
        check("t1_mask_de", int'(mask_de), 1);
        check("t1_mask_valid", int'(mask_valid), 1);
        mask_chk("t1_h141", 141, 200, 100, 0);
        mask_chk("t1_s63", 120, 63, 100, 0);
        mask_chk("t1_h100", 100, 64, 32, 1);
        mask_chk("t1_h140", 140, 256, 255, 1);
        mask_chk("t1_v31", 120, 200, 31, 0);

        // Test 2: wrapped window 340..20.
        h_min = 9'd340; h_max = 9'd20;
        send_vs();
        mask_chk("t2_h350", 350, 200, 100, 1);
        mask_chk("t2_h10", 10, 200, 100, 1);
        mask_chk("t2_h0", 0, 200, 100, 1);
        mask_chk("t2_h180", 180, 200, 100, 0);
        mask_chk("t2_h340", 340, 200, 100, 1);
        mask_chk("t2_h339", 339, 200, 100, 0);
        mask_chk("t2_h21", 21, 200, 100, 0);

        // Test 3: 10x10 block at x 100..109, y 50..59.
        h_min = 9'd100; h_max = 9'd140;
        send_vs();
        send_frame(120, 64, 100, 109, 50, 59);
        fd_before = fd_cnt;
        send_vs();
        check("t3_fd", fd_cnt - fd_before, 1);
        check("t3_pix_count", int'(pix_count), 100);
        check("t3_bbox_x0", int'(bbox_x0), 100);
        check("t3_bbox_x1", int'(bbox_x1), 109);
        check("t3_bbox_y0", int'(bbox_y0), 50);
        check("t3_bbox_y1", int'(bbox_y1), 59);
        check("t3_obj_found", int'(obj_found), 1);
        wait_rv("t3_rv", 200);
        check("t3_cen_x", int'(cen_x), 104);
        check("t3_cen_y", int'(cen_y), 54);

        // Test 4: 20 hits below MIN_PIX, then an empty frame.
        send_frame(16, 12, 5, 6, 0, 9);
        send_vs();
        check("t4_pix_count", int'(pix_count), 20);
        check("t4_obj_found", int'(obj_found), 0);
        check("t4_bbox_x1", int'(bbox_x1), 6);
        check("t4_bbox_y1", int'(bbox_y1), 9);
        wait_rv("t4_rv", 200);
        check("t4_cen_x", int'(cen_x), 5);
        check("t4_cen_y", int'(cen_y), 4);
        send_frame(16, 4, 1, 0, 0, 0);
        send_vs();
        check("t4e_pix_count", int'(pix_count), 0);
        check("t4e_bbox_x0", int'(bbox_x0), 0);
        check("t4e_bbox_y0", int'(bbox_y0), 0);
        check("t4e_bbox_x1", int'(bbox_x1), 0);
        wait_rv("t4e_rv", 10);
        check("t4e_rv_lat", rv_cyc - fd_cyc, 1);
        check("t4e_cen_x", int'(cen_x), 0);
        check("t4e_cen_y", int'(cen_y), 0);

        // Test 5: short vblank aborts the running divide.
        send_frame(16, 12, 5, 6, 0, 9);
        send_vs();
        rv_before = rv_cnt;
        send_frame(12, 1, 8, 11, 0, 0);
        send_vs();
        check("t5_no_old_rv", rv_cnt - rv_before, 0);
        check("t5_pix_count", int'(pix_count), 4);
        check("t5_bbox_x0", int'(bbox_x0), 8);
        wait_rv("t5_rv", 200);
        check("t5_cen_x", int'(cen_x), 9);
        check("t5_cen_y", int'(cen_y), 0);
        repeat (100) @(negedge clk);
        check("t5_single_rv", rv_cnt - rv_before, 1);

        // Test 6a: reset mid-frame.
        send_frame(16, 2, 5, 6, 0, 1);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("t6a_pix_count", int'(pix_count), 0);
        check("t6a_cen_x", int'(cen_x), 0);
        check("t6a_bbox_x0", int'(bbox_x0), 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Test 6b: reset mid-divide, then silence until the next vs edge.
        send_vs();
        send_frame(16, 12, 5, 6, 0, 9);
        send_vs();
        repeat (10) @(negedge clk);
        check("t6b_state_div_x", int'(dbg_div_state), 1);
        reset_n = 1'b0;
        #1;
        check("t6b_pix_count", int'(pix_count), 0);
        check("t6b_bbox_x1", int'(bbox_x1), 0);
        check("t6b_state", int'(dbg_div_state), 0);
        @(negedge clk);
        reset_n = 1'b1;
        fd_before = fd_cnt;
        rv_before = rv_cnt;
        repeat (120) @(negedge clk);
        check("t6b_no_fd", fd_cnt - fd_before, 0);
        check("t6b_no_rv", rv_cnt - rv_before, 0);

        // Recovery on the next full frame.
        send_vs();
        send_frame(16, 12, 5, 6, 0, 9);
        send_vs();
        check("t6_rec_pix_count", int'(pix_count), 20);
        check("t6_rec_bbox_x0", int'(bbox_x0), 5);
        wait_rv("t6_rec_rv", 200);
        check("t6_rec_cen_x", int'(cen_x), 5);
        check("t6_rec_cen_y", int'(cen_y), 4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
